reindeer_multi_channel_timer: RTL and testbench

Parametrised successor to the single-comparator machine timer. It provides one shared COUNTER_WIDTH-bit mtime with a programmable prescaler, plus NUM_CH independent compare channels. Each channel runs in one-shot or auto-reload periodic mode and has sticky, write-1-to-clear pending status. It sits on the core's peripheral register bus and drives per-channel interrupt lines into the interrupt controller.

---
 rtl/reindeer_timer_pkg.sv | 30 +++
 rtl/reindeer_timer_channel.sv | 61 ++++++
 rtl/reindeer_multi_channel_timer.sv | 177 +++++++++++++++++
 tb/tb_reindeer_multi_channel_timer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reindeer_timer_pkg.sv
// Shared constants and types for the multi-channel machine timer.
// Register word offsets, control bit positions and channel control layout.
package reindeer_timer_pkg;

  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_MTIME_LO = 1;
  localparam int ADDR_MTIME_HI = 2;
  localparam int ADDR_STATUS   = 3;
  localparam int ADDR_CH_BASE  = 4;
  localparam int CH_STRIDE     = 4;

  localparam int OFF_CMP_LO  = 0;
  localparam int OFF_CMP_HI  = 1;
  localparam int OFF_CH_CTRL = 2;
  localparam int OFF_PERIOD  = 3;

  localparam int CTRL_COUNT_EN_BIT = 0;
  localparam int CTRL_PRESCALE_LSB = 8;

  localparam int CH_EN_BIT       = 0;
  localparam int CH_PERIODIC_BIT = 1;
  localparam int CH_IRQ_EN_BIT   = 2;

  typedef struct packed {
    logic irq_en;
    logic periodic;
    logic en;
  } ch_ctrl_t;

endpackage

// File: rtl/reindeer_timer_channel.sv
// One compare channel: compare value, reload period, control and pending.
// Bus writes to the compare value take priority over periodic reload.
module reindeer_timer_channel
  import reindeer_timer_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     sync_reset,
  input  logic [COUNTER_WIDTH-1:0] mtime,
  input  logic                     wr_cmp_lo,
  input  logic                     wr_cmp_hi,
  input  logic                     wr_ctrl,
  input  logic                     wr_period,
  input  logic                     clr,
  input  logic [XLEN-1:0]          wr_data,
  output logic [COUNTER_WIDTH-1:0] cmp,
  output logic [XLEN-1:0]          period,
  output ch_ctrl_t                 ctrl,
  output logic                     pending
);

  localparam int EXT_W = 2 * XLEN;
  localparam bit HAS_HI = COUNTER_WIDTH > XLEN;

  logic [EXT_W-1:0] cmp_wr;
  logic             cmp_write;
  logic             match;
  logic             reload;

  assign cmp_write = wr_cmp_lo | (wr_cmp_hi & HAS_HI);
  assign match = ctrl.en && (mtime >= cmp);
  assign reload = match && ctrl.periodic && (period != '0);

  // Merge a half-word bus write into the current compare value.
  always_comb begin
    cmp_wr = EXT_W'(cmp);
    if (wr_cmp_lo) cmp_wr[XLEN-1:0] = wr_data;
    if (wr_cmp_hi && HAS_HI) cmp_wr[EXT_W-1:XLEN] = wr_data;
  end

  // Channel registers; a compare write drops both reload and pending.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      cmp     <= '0;
      period  <= '0;
      ctrl    <= '0;
      pending <= 1'b0;
    end else begin
      if (cmp_write) cmp <= cmp_wr[COUNTER_WIDTH-1:0];
      else if (reload) cmp <= cmp + COUNTER_WIDTH'(period);
      if (wr_period) period <= wr_data;
      if (wr_ctrl) ctrl <= ch_ctrl_t'(wr_data[CH_IRQ_EN_BIT:CH_EN_BIT]);
      if (cmp_write) pending <= 1'b0;
      else if (match) pending <= 1'b1;
      else if (clr) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/reindeer_multi_channel_timer.sv
// Shared mtime with prescaler plus NUM_CH compare channels on the
// peripheral register bus, with registered reads and interrupts.
module reindeer_multi_channel_timer
  import reindeer_timer_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_CH        = 4,
  parameter int PRESCALE_BITS = 8,
  parameter int ADDR_W        = 6
) (
  input  logic              clk,
  input  logic              sync_reset,
  input  logic              reg_wr_en,
  input  logic              reg_rd_en,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [XLEN-1:0]   reg_wr_data,
  output logic [XLEN-1:0]   reg_rd_data,
  output logic              reg_rd_valid,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  localparam int EXT_W = 2 * XLEN;
  localparam bit HAS_HI = COUNTER_WIDTH > XLEN;

  logic                     count_en;
  logic [PRESCALE_BITS-1:0] prescale;
  logic [PRESCALE_BITS-1:0] presc;
  logic                     tick;
  logic [COUNTER_WIDTH-1:0] mtime;
  logic [EXT_W-1:0]         mt_ext;
  logic [EXT_W-1:0]         mt_nxt;
  logic [XLEN-1:0]          mtime_hi_shadow;
  logic [XLEN-1:0]          rd_mux;
  logic [EXT_W-1:0]         cmp_ext;

  logic [ADDR_W-3:0] word;
  logic [1:0]        off;
  logic              sel_ctrl;
  logic              sel_lo;
  logic              sel_hi;
  logic              sel_status;
  logic              wr_ctrl;
  logic              wr_lo;
  logic              wr_hi;

  logic [NUM_CH-1:0]        ch_sel;
  logic [NUM_CH-1:0]        pending;
  logic [NUM_CH-1:0]        irq_en_vec;
  logic [COUNTER_WIDTH-1:0] cmp_q    [NUM_CH];
  logic [XLEN-1:0]          period_q [NUM_CH];
  ch_ctrl_t                 ctrl_q   [NUM_CH];

  assign word = reg_addr[ADDR_W-1:2];
  assign off  = reg_addr[1:0];

  assign sel_ctrl   = (word == '0) && (off == 2'(ADDR_CTRL));
  assign sel_lo     = (word == '0) && (off == 2'(ADDR_MTIME_LO));
  assign sel_hi     = (word == '0) && (off == 2'(ADDR_MTIME_HI));
  assign sel_status = (word == '0) && (off == 2'(ADDR_STATUS));

  assign wr_ctrl = reg_wr_en && sel_ctrl;
  assign wr_lo   = reg_wr_en && sel_lo;
  assign wr_hi   = reg_wr_en && sel_hi && HAS_HI;

  assign tick = count_en && (presc == prescale);

  // Next mtime: a bus write replaces the value and swallows any tick.
  always_comb begin
    mt_ext = EXT_W'(mtime);
    mt_nxt = mt_ext;
    if (tick) mt_nxt = mt_ext + EXT_W'(1);
    if (wr_lo || wr_hi) begin
      mt_nxt = mt_ext;
      if (wr_lo) mt_nxt[XLEN-1:0] = reg_wr_data;
      if (wr_hi) mt_nxt[EXT_W-1:XLEN] = reg_wr_data;
    end
  end

  // Control, prescaler phase and mtime state.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      count_en <= 1'b0;
      prescale <= '0;
      presc    <= '0;
      mtime    <= '0;
    end else begin
      if (wr_ctrl) begin
        count_en <= reg_wr_data[CTRL_COUNT_EN_BIT];
        prescale <= reg_wr_data[CTRL_PRESCALE_LSB +: PRESCALE_BITS];
      end
      if (wr_ctrl || !count_en || tick) presc <= '0;
      else presc <= presc + PRESCALE_BITS'(1);
      mtime <= mt_nxt[COUNTER_WIDTH-1:0];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_sel[g] =
      word == (ADDR_W-2)'(ADDR_CH_BASE / CH_STRIDE + g);
    assign irq_en_vec[g] = ctrl_q[g].irq_en;

    reindeer_timer_channel #(
      .XLEN          (XLEN),
      .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_ch (
      .clk        (clk),
      .sync_reset (sync_reset),
      .mtime      (mtime),
      .wr_cmp_lo  (reg_wr_en && ch_sel[g] && off == 2'(OFF_CMP_LO)),
      .wr_cmp_hi  (reg_wr_en && ch_sel[g] && off == 2'(OFF_CMP_HI)),
      .wr_ctrl    (reg_wr_en && ch_sel[g] && off == 2'(OFF_CH_CTRL)),
      .wr_period  (reg_wr_en && ch_sel[g] && off == 2'(OFF_PERIOD)),
      .clr        (reg_wr_en && sel_status && reg_wr_data[g]),
      .wr_data    (reg_wr_data),
      .cmp        (cmp_q[g]),
      .period     (period_q[g]),
      .ctrl       (ctrl_q[g]),
      .pending    (pending[g])
    );
  end

  // Read mux; unmapped addresses fall through to zero.
  always_comb begin
    rd_mux  = '0;
    cmp_ext = '0;
    unique case (1'b1)
      sel_ctrl: begin
        rd_mux[CTRL_COUNT_EN_BIT] = count_en;
        rd_mux[CTRL_PRESCALE_LSB +: PRESCALE_BITS] = prescale;
      end
      sel_lo:     rd_mux = mt_ext[XLEN-1:0];
      sel_hi:     rd_mux = mtime_hi_shadow;
      sel_status: rd_mux = XLEN'(pending);
      default:    ;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel[c]) begin
        cmp_ext = EXT_W'(cmp_q[c]);
        unique case (1'b1)
          off == 2'(OFF_CMP_LO):  rd_mux = cmp_ext[XLEN-1:0];
          off == 2'(OFF_CMP_HI):  rd_mux = cmp_ext[EXT_W-1:XLEN];
          off == 2'(OFF_CH_CTRL): rd_mux = XLEN'(ctrl_q[c]);
          default:                rd_mux = period_q[c];
        endcase
      end
    end
  end

  // Registered read port; a low-half mtime read snapshots the high half.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      reg_rd_data     <= '0;
      reg_rd_valid    <= 1'b0;
      mtime_hi_shadow <= '0;
    end else begin
      reg_rd_valid <= reg_rd_en;
      if (reg_rd_en) begin
        reg_rd_data <= rd_mux;
        if (sel_lo) mtime_hi_shadow <= mt_ext[EXT_W-1:XLEN];
      end
    end
  end

  // Registered interrupt lines.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      irq     <= '0;
      irq_any <= 1'b0;
    end else begin
      irq     <= pending & irq_en_vec;
      irq_any <= |(pending & irq_en_vec);
    end
  end

endmodule

// File: tb/tb_reindeer_multi_channel_timer.sv
// Directed bench with a cycle-level reference model of the timer.
// Outputs are checked against the model every cycle plus literal values.
module tb_reindeer_multi_channel_timer;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wr_data;
  logic [31:0] reg_rd_data;
  logic        reg_rd_valid;
  logic [3:0]  irq;
  logic        irq_any;

  always #5 clk = ~clk;

  reindeer_multi_channel_timer #(
    .XLEN          (32),
    .COUNTER_WIDTH (64),
    .NUM_CH        (4),
    .PRESCALE_BITS (8),
    .ADDR_W        (6)
  ) dut (
    .clk          (clk),
    .sync_reset   (sync_reset),
    .reg_wr_en    (reg_wr_en),
    .reg_rd_en    (reg_rd_en),
    .reg_addr     (reg_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_rd_data  (reg_rd_data),
    .reg_rd_valid (reg_rd_valid),
    .irq          (irq),
    .irq_any      (irq_any)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Reference model state
  logic [63:0] m_mtime;
  logic [63:0] m_cmp [4];
  logic [31:0] m_period [4];
  logic [2:0]  m_chc [4];
  logic [3:0]  m_pend;
  logic [3:0]  m_irq;
  logic        m_any;
  logic        m_valid;
  logic [31:0] m_rdata;
  logic [31:0] m_shadow;
  logic        m_cen;
  logic [7:0]  m_pre;
  int          m_phase;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [5:0] a);
    int ai;
    int c;
    int k;
    ai = int'(a);
    if (ai == 0) return {16'h0, m_pre, 7'h0, m_cen};
    if (ai == 1) return m_mtime[31:0];
    if (ai == 2) return m_shadow;
    if (ai == 3) return {28'h0, m_pend};
    if (ai >= 4 && ai < 20) begin
      c = (ai - 4) / 4;
      k = (ai - 4) % 4;
      if (k == 0) return m_cmp[c][31:0];
      if (k == 1) return m_cmp[c][63:32];
      if (k == 2) return {29'h0, m_chc[c]};
      return m_period[c];
    end
    return 32'h0;
  endfunction

  // Model: all next values are derived from pre-edge state and inputs.
  always @(posedge clk) begin : model
    bit         tick;
    logic [3:0] match;
    logic [3:0] ie;
    bit         cw;
    int         a;
    a = int'(reg_addr);
    if (sync_reset) begin
      m_mtime = '0; m_pend = '0; m_irq = '0; m_any = 0;
      m_valid = 0; m_rdata = '0; m_shadow = '0;
      m_cen = 0; m_pre = '0; m_phase = 0;
      for (int c = 0; c < 4; c++) begin
        m_cmp[c] = '0; m_period[c] = '0; m_chc[c] = '0;
      end
    end else begin
      tick = m_cen && (m_phase == int'(m_pre));
      for (int c = 0; c < 4; c++) begin
        match[c] = m_chc[c][0] && (m_mtime >= m_cmp[c]);
        ie[c] = m_chc[c][2];
      end
      m_irq = m_pend & ie;
      m_any = |m_irq;
      m_valid = reg_rd_en;
      if (reg_rd_en) begin
        m_rdata = m_read(reg_addr);
        if (a == 1) m_shadow = m_mtime[63:32];
      end
      for (int c = 0; c < 4; c++) begin
        cw = reg_wr_en && (a == 4 + 4 * c || a == 5 + 4 * c);
        if (cw) m_pend[c] = 1'b0;
        else if (match[c]) m_pend[c] = 1'b1;
        else if (reg_wr_en && a == 3 && reg_wr_data[c]) m_pend[c] = 1'b0;
        if (cw) begin
          if (a == 4 + 4 * c) m_cmp[c][31:0] = reg_wr_data;
          else m_cmp[c][63:32] = reg_wr_data;
        end else if (match[c] && m_chc[c][1] && m_period[c] != 0) begin
          m_cmp[c] = m_cmp[c] + {32'h0, m_period[c]};
        end
        if (reg_wr_en && a == 6 + 4 * c) m_chc[c] = reg_wr_data[2:0];
        if (reg_wr_en && a == 7 + 4 * c) m_period[c] = reg_wr_data;
      end
      if (reg_wr_en && a == 1) m_mtime[31:0] = reg_wr_data;
      else if (reg_wr_en && a == 2) m_mtime[63:32] = reg_wr_data;
      else if (tick) m_mtime = m_mtime + 64'd1;
      if ((reg_wr_en && a == 0) || !m_cen || tick) m_phase = 0;
      else m_phase = m_phase + 1;
      if (reg_wr_en && a == 0) begin
        m_cen = reg_wr_data[0];
        m_pre = reg_wr_data[15:8];
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("irq", 64'(irq), 64'(m_irq));
      chk("irq_any", 64'(irq_any), 64'(m_any));
      chk("rd_valid", 64'(reg_rd_valid), 64'(m_valid));
      chk("rd_data", 64'(reg_rd_data), 64'(m_rdata));
    end
  end

  task automatic wr(input int a, input logic [31:0] d);
    reg_wr_en = 1'b1;
    reg_addr = 6'(a);
    reg_wr_data = d;
    @(negedge clk);
    reg_wr_en = 1'b0;
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input string name);
    reg_rd_en = 1'b1;
    reg_addr = 6'(a);
    @(negedge clk);
    reg_rd_en = 1'b0;
    chk(name, 64'(reg_rd_data), 64'(exp));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_irq(input int b, input int maxc, output int k);
    k = 0;
    while (!irq[b] && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (!irq[b]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_irq%0d: no irq after %0d cycles", b, k);
    end
  endtask

  initial begin
    int k;
    sync_reset = 1'b1;
    reg_wr_en = 1'b0;
    reg_rd_en = 1'b0;
    reg_addr = '0;
    reg_wr_data = '0;
    repeat (3) @(negedge clk);
    sync_reset = 1'b0;
    chk_on = 1'b1;
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_irq_any", 64'(irq_any), 64'h0);
    chk("rst_rd_valid", 64'(reg_rd_valid), 64'h0);
    chk("rst_rd_data", 64'(reg_rd_data), 64'h0);
    rd(0, 32'h0, "rst_ctrl");

    // One-shot match on ch0 at mtime 5
    wr(4, 5); wr(5, 0); wr(6, 5);
    wr(0, 32'h1);
    wait_irq(0, 20, k);
    chk("t1_latency", 64'(k), 64'd7);
    chk("t1_irq", 64'(irq), 64'h1);
    chk("t1_irq_any", 64'(irq_any), 64'h1);
    wr(0, 0); wr(6, 0); wr(3, 1);

    // Prescaler 3, freeze, phase restart
    wr(1, 0); wr(2, 0);
    wr(0, 32'h301);
    idle(11);
    rd(1, 32'd2, "t2_prescale");
    wr(0, 0);
    idle(10);
    rd(1, 32'd3, "t2_freeze");
    wr(0, 32'h301);
    idle(2);
    wr(0, 32'h301);
    idle(6);
    rd(1, 32'd4, "t2_phase");
    wr(0, 0);

    // Periodic ch1: matches at 10, 20, 30
    wr(1, 0); wr(2, 0);
    wr(8, 10); wr(9, 0); wr(11, 10); wr(10, 7);
    wr(0, 32'h1);
    for (int i = 0; i < 3; i++) begin
      wait_irq(1, 40, k);
      wr(3, 2);
      rd(3, 32'h0, "t3_w1c");
    end
    wr(0, 0);
    rd(8, 32'd40, "t3_cmp40");
    rd(11, 32'd10, "t3_period");
    wr(10, 0); wr(3, 2);

    // Compare wrap on ch2
    wr(1, 32'hFFFF_FFFE); wr(2, 32'hFFFF_FFFF);
    wr(12, 32'hFFFF_FFFF); wr(13, 32'hFFFF_FFFF);
    wr(15, 4); wr(14, 7);
    wr(0, 32'h1);
    wait_irq(2, 10, k);
    chk("t4_wrap_latency", 64'(k), 64'd3);
    wr(3, 4);
    rd(12, 32'd3, "t4_cmp_wrap");
    wait_irq(2, 10, k);
    chk("t4_next_latency", 64'(k), 64'd2);
    wr(0, 0);
    rd(1, 32'd6, "t4_mtime_lo");
    rd(2, 32'd0, "t4_mtime_hi");
    rd(12, 32'd7, "t4_cmp_next");
    rd(13, 32'd0, "t4_cmp_hi");
    wr(14, 0); wr(3, 4);

    // Atomic 64-bit read across a carry
    wr(1, 32'hFFFF_FFFF); wr(2, 32'h1);
    wr(0, 32'h1);
    rd(1, 32'hFFFF_FFFF, "t5_lo");
    rd(2, 32'h1, "t5_hi_shadow");
    wr(0, 0);

    // Set beats W1C; CMP write beats reload
    wr(1, 0); wr(2, 0);
    wr(16, 5); wr(17, 0); wr(19, 3); wr(18, 7);
    wr(0, 32'h1);
    idle(8);
    wr(3, 8);
    rd(3, 32'h8, "t6_set_wins");
    wr(3, 8);
    wr(16, 100);
    wr(0, 0);
    rd(16, 32'd100, "t6_cmp_wins");

    // All four irqs then reset
    wr(1, 200); wr(2, 0);
    wr(6, 5); wr(10, 5); wr(14, 5); wr(18, 5);
    idle(3);
    chk("t7_irq_all", 64'(irq), 64'hF);
    chk("t7_irq_any", 64'(irq_any), 64'h1);
    sync_reset = 1'b1;
    reg_rd_en = 1'b1;
    reg_addr = 6'd3;
    @(negedge clk);
    sync_reset = 1'b0;
    reg_rd_en = 1'b0;
    chk("t7_rst_irq", 64'(irq), 64'h0);
    chk("t7_rst_any", 64'(irq_any), 64'h0);
    chk("t7_rst_valid", 64'(reg_rd_valid), 64'h0);
    chk("t7_rst_data", 64'(reg_rd_data), 64'h0);
    rd(3, 32'h0, "t7_rst_status");
    rd(16, 32'h0, "t7_rst_cmp3");
    rd(1, 32'h0, "t7_rst_mtime");
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
